// File: rtl/int_bridge_pkg.sv
// int_bridge_pkg: shared definitions for the int_bridge request bridge.
// Holds the FSM state encoding, the filler byte driven in a read's data
// phase, the request-entry field widths and the request-entry payload.
package int_bridge_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_ADDR   = 2'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 2'd2;
  localparam logic [STATE_W-1:0] ST_RDWAIT = 2'd3;

  localparam logic [DATA_W-1:0] RD_FILLER = 8'h00;

  // One queued request: rw=1 read, rw=0 write.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_entry_t;

  // Address-phase byte presented to egress.
  function automatic logic [DATA_W-1:0] addr_byte(input req_entry_t e);
    return {e.rw, e.addr};
  endfunction

endpackage

// File: rtl/int_bridge_fifo.sv
// int_bridge_fifo: request FIFO for int_bridge.
// Ports: clk, rst (sync, active-high), push/din write side, pop/head_c
// read side (head_c is the current head entry), full_c/empty_c status.
// Push while full and pop while empty are ignored; pointers carry one
// extra wrap bit so full and empty are distinguishable.
module int_bridge_fifo
  import int_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  req_entry_t din,
  input  logic       pop,
  output req_entry_t head_c,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  req_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;
  assign head_c  = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed when non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/int_bridge.sv
// int_bridge: queues core read/write requests and serialises each one to
// egress as an address byte {rw,addr} followed by a data byte (write data,
// or a filler for reads), then returns read data as a one-cycle pulse.
// Ports: clk, rst (sync, active-high); core side req_valid/req_ready/
// req_rw/req_addr/req_wdata; egress side int2eg_data/int_datavalid/
// int_datardy/eg2int_data; completion rsp_valid/rsp_rdata; completed
// transaction counters wr_count/rd_count.
// Build option: define INT_BRIDGE_STATS_EN to enable the counters;
// otherwise they are tied to zero.
module int_bridge
  import int_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] int2eg_data,
  output logic              int_datavalid,
  input  logic              int_datardy,
  input  logic [DATA_W-1:0] eg2int_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_n;
  req_entry_t         cur;
  req_entry_t         cur_n;
  req_entry_t         din_c;
  req_entry_t         head_c;
  logic               full_c;
  logic               empty_c;
  logic               pop_c;
  logic               start_c;
  logic               beat_c;
  logic [DATA_W-1:0]  data_n;
  logic               valid_n;
  logic               rsp_valid_n;
  logic [DATA_W-1:0]  rsp_rdata_n;

  assign din_c     = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
  assign req_ready = !full_c;
  assign beat_c    = int_datavalid && int_datardy;

  int_bridge_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (req_valid && req_ready),
    .din     (din_c),
    .pop     (pop_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state;
    cur_n       = cur;
    data_n      = int2eg_data;
    valid_n     = int_datavalid;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    start_c     = 1'b0;
    pop_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        start_c = !empty_c;
      end
      ST_ADDR: begin
        if (beat_c) begin
          state_n = ST_DATA;
          data_n  = cur.rw ? RD_FILLER : cur.wdata;
        end
      end
      ST_DATA: begin
        if (beat_c) begin
          if (cur.rw) begin
            state_n = ST_RDWAIT;
            valid_n = 1'b0;
            data_n  = '0;
          end else if (!empty_c) begin
            start_c = 1'b1;
          end else begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            data_n  = '0;
          end
        end
      end
      ST_RDWAIT: begin
        rsp_valid_n = 1'b1;
        rsp_rdata_n = eg2int_data;
        if (!empty_c) start_c = 1'b1;
        else          state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
        data_n  = '0;
      end
    endcase

    // Common entry into ADDR: pop the head and present its address byte.
    if (start_c) begin
      pop_c   = 1'b1;
      state_n = ST_ADDR;
      cur_n   = head_c;
      data_n  = addr_byte(head_c);
      valid_n = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cur           <= '0;
      int2eg_data   <= '0;
      int_datavalid <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      state         <= state_n;
      cur           <= cur_n;
      int2eg_data   <= data_n;
      int_datavalid <= valid_n;
      rsp_valid     <= rsp_valid_n;
      rsp_rdata     <= rsp_rdata_n;
    end
  end

`ifdef INT_BRIDGE_STATS_EN
  logic inc_wr_c;
  logic inc_rd_c;

  assign inc_wr_c = (state == ST_DATA) && beat_c && !cur.rw;
  assign inc_rd_c = (state == ST_RDWAIT);

  // Completed-transaction counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (inc_wr_c) wr_count <= wr_count + CNT_W'(1);
      if (inc_rd_c) rd_count <= rd_count + CNT_W'(1);
    end
  end
`else
  assign wr_count = '0;
  assign rd_count = '0;
`endif

endmodule
